chunked_addsub: RTL

Multi-cycle, parametrised adder/subtractor that processes a WIDTH-bit operand pair in CHUNK-bit slices, least-significant slice first, one slice per clock. It succeeds the fixed 4-bit ripple adder with configurable width, a subtract mode, a signed-overflow flag and a start/busy/done handshake. It serves datapaths that trade latency for a short carry chain: the critical path is one CHUNK-bit ripple instead of a WIDTH-bit ripple.

---
 rtl/chunked_addsub.sv | 98 +++++++++
 1 files changed

// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: adds a WIDTH-bit operand pair CHUNK bits per clock,
// least-significant slice first, with start/busy/done handshake and signed overflow.
module chunked_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [IW-1:0]    idx;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   sum;
    logic             ovf;
    logic             last;

    // One CHUNK-bit ripple on the current slice; the carry into the slice MSB is
    // recovered as a^b^s at that bit, so no separate narrower adder is needed.
    always_comb begin
        a_sl = a_q[idx*CHUNK +: CHUNK];
        b_sl = b_q[idx*CHUNK +: CHUNK];
        sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
        ovf  = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ sum[CHUNK-1] ^ sum[CHUNK];
        last = (idx == IW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            V     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract is A + ~B + !Cin, so invert B and the carry-in up front.
                        a_q   <= A;
                        b_q   <= sub ? ~B : B;
                        carry <= Cin ^ sub;
                        idx   <= '0;
                        Cout  <= 1'b0;
                        V     <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    S[idx*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
                    carry                 <= sum[CHUNK];
                    if (last) begin
                        idx   <= '0;
                        Cout  <= sum[CHUNK];
                        V     <= ovf;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
